// File: rtl/access_pkg.sv
// access_pkg: shared types and constants for the access controller.
//   state_e     - controller state encoding (2-bit)
//   MS_CNT_W    - width of the millisecond down-counter
//   cyc_per_ms  - clock cycles per millisecond for a given clock frequency
package access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_DENY    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_e;

    localparam int MS_CNT_W = 16;

    function automatic int cyc_per_ms(input int clk_hz);
        return clk_hz / 1000;
    endfunction

endpackage

// File: rtl/access_ctrl_ms_tick_gen.sv
// ms_tick_gen: millisecond prescaler.
//   clk_i, rst_n_i : clock, async active-low reset
//   clr_i          : synchronous clear, restarts the millisecond period
//   ms_tick_o      : one-cycle pulse on the last cycle of every CYC_PER_MS-cycle period
module ms_tick_gen #(
    parameter int CYC_PER_MS = 50000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    output logic ms_tick_o
);

    localparam int CW = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYC_PER_MS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign ms_tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || ms_tick_o) cnt_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/access_ctrl.sv
// access_ctrl: turns allow/deny decisions into timed relay/LED actions with
// consecutive-denial lockout.
//   clk, rst_n            : clock, async active-low reset
//   auth_valid/auth_allow : one-cycle decision strobe and its value
//   relay_on, led_green   : high for the whole GRANT action
//   led_red               : high in DENY and LOCKOUT
//   lockout, busy         : state indicators
//   req_drop              : one-cycle pulse for a decision arriving while busy
//   fail_cnt              : consecutive-denial count
//   grant_cnt, deny_cnt   : access statistics, only when ACCESS_STATS_EN is
//                           defined; otherwise tied to 0
module access_ctrl
    import access_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int UNLOCK_MS   = 3000,
    parameter int DENY_MS     = 1000,
    parameter int LOCKOUT_MS  = 30000,
    parameter int MAX_FAILS   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        auth_valid,
    input  logic        auth_allow,
    output logic        relay_on,
    output logic        led_green,
    output logic        led_red,
    output logic        lockout,
    output logic        busy,
    output logic        req_drop,
    output logic [7:0]  fail_cnt,
    output logic [15:0] grant_cnt,
    output logic [15:0] deny_cnt
);

    localparam int CYC = cyc_per_ms(CLK_FREQ_HZ);
    localparam logic [MS_CNT_W-1:0] UNLOCK_L  = MS_CNT_W'(UNLOCK_MS);
    localparam logic [MS_CNT_W-1:0] DENY_L    = MS_CNT_W'(DENY_MS);
    localparam logic [MS_CNT_W-1:0] LOCKOUT_L = MS_CNT_W'(LOCKOUT_MS);

    state_e              state_q, state_d;
    logic [MS_CNT_W-1:0] ms_q, ms_d;
    logic [7:0]          fail_q, fail_d;
    logic                clr, ms_tick, expire;
    logic                relay_q, green_q, red_q, lock_q, busy_q, drop_q, drop_d;

    ms_tick_gen #(.CYC_PER_MS(CYC)) u_tick (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .clr_i     (clr),
        .ms_tick_o (ms_tick)
    );

    // Last tick of the last millisecond: the state stays non-IDLE this cycle
    // and IDLE is reached on the next edge.
    assign expire = ms_tick && (ms_q == MS_CNT_W'(1));

    always_comb begin
        state_d = state_q;
        ms_d    = ms_q;
        fail_d  = fail_q;
        clr     = 1'b0;
        drop_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (auth_valid) begin
                    clr = 1'b1;
                    if (auth_allow) begin
                        state_d = ST_GRANT;
                        ms_d    = UNLOCK_L;
                        fail_d  = '0;
                    end else if (int'(fail_q) + 1 < MAX_FAILS) begin
                        state_d = ST_DENY;
                        ms_d    = DENY_L;
                        fail_d  = (fail_q == 8'hFF) ? 8'hFF : fail_q + 8'd1;
                    end else begin
                        state_d = ST_LOCKOUT;
                        ms_d    = LOCKOUT_L;
                        fail_d  = '0;
                    end
                end
            end
            default: begin
                drop_d = auth_valid;
                if (ms_tick) ms_d = ms_q - MS_CNT_W'(1);
                if (expire)  state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ms_q    <= '0;
            fail_q  <= '0;
            relay_q <= 1'b0;
            green_q <= 1'b0;
            red_q   <= 1'b0;
            lock_q  <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ms_q    <= ms_d;
            fail_q  <= fail_d;
            relay_q <= (state_d == ST_GRANT);
            green_q <= (state_d == ST_GRANT);
            red_q   <= (state_d == ST_DENY) || (state_d == ST_LOCKOUT);
            lock_q  <= (state_d == ST_LOCKOUT);
            busy_q  <= (state_d != ST_IDLE);
            drop_q  <= drop_d;
        end
    end

    assign relay_on  = relay_q;
    assign led_green = green_q;
    assign led_red   = red_q;
    assign lockout   = lock_q;
    assign busy      = busy_q;
    assign req_drop  = drop_q;
    assign fail_cnt  = fail_q;

`ifdef ACCESS_STATS_EN
    logic [15:0] grant_q, deny_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= '0;
            deny_q  <= '0;
        end else if (state_q == ST_IDLE) begin
            if (state_d == ST_GRANT && grant_q != 16'hFFFF)
                grant_q <= grant_q + 16'd1;
            if ((state_d == ST_DENY || state_d == ST_LOCKOUT) && deny_q != 16'hFFFF)
                deny_q <= deny_q + 16'd1;
        end
    end

    assign grant_cnt = grant_q;
    assign deny_cnt  = deny_q;
`else
    assign grant_cnt = '0;
    assign deny_cnt  = '0;
`endif

endmodule
